// File: rtl/glyph_plotter.sv
`default_nettype none
// ============================================================================
// glyph_plotter : raster-walks one scaled bitmap glyph, one VGA pixel per clk
// Rev 1.0
// ============================================================================
module glyph_plotter #(
    parameter int GLYPH_W = 3,
    parameter int GLYPH_H = 5,
    parameter int SCALE   = 1,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3,
    parameter int X_MAX   = 159,
    parameter int Y_MAX   = 119,
    parameter int DRAW_BG = 0,
    parameter int CLIP    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [GLYPH_W*GLYPH_H-1:0] pattern,
    input  logic [X_W-1:0]             x0,
    input  logic [Y_W-1:0]             y0,
    input  logic [COLOR_W-1:0]         fg_color,
    input  logic [COLOR_W-1:0]         bg_color,
    output logic [X_W-1:0]             x,
    output logic [Y_W-1:0]             y,
    output logic [COLOR_W-1:0]         colour,
    output logic                       plot,
    output logic                       busy,
    output logic                       done
);
    localparam int NPIX = GLYPH_W * GLYPH_H;
    localparam int GXW  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int GYW  = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam int SW   = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int XS   = X_W + 1;
    localparam int YS   = Y_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state, w_next;
    logic [NPIX-1:0]      r_pat;
    logic [X_W-1:0]       r_x0, r_x;
    logic [Y_W-1:0]       r_y0, r_y;
    logic [COLOR_W-1:0]   r_fg, r_bg, r_colour;
    logic                 r_plot;
    logic [GXW-1:0]       r_gx;
    logic [GYW-1:0]       r_gy;
    logic                 r_fin;

    logic                 w_accept, w_emit;
    logic [SW-1:0]        w_sx, w_sy;
    logic                 w_sx_last, w_sy_last, w_gx_last, w_gy_last;
    logic                 w_row_end, w_glyph_end;
    logic [XS-1:0]        w_xsum;
    logic [YS-1:0]        w_ysum;
    logic [IW-1:0]        w_idx;
    logic                 w_bit, w_vis;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // r_fin marks that the last pixel has been issued; DRAW then spends one
    // more cycle so the final pixel is visible before done rises.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_emit   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next   = S_DRAW;
                    w_accept = 1'b1;
                end
            end
            S_DRAW: begin
                if (r_fin) w_next = S_DONE;
                else       w_emit = 1'b1;
            end
            S_DONE: begin
                w_accept = start;
                w_next   = start ? S_DRAW : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    generate
        if (SCALE > 1) begin : g_scale
            logic [SW-1:0] r_sx, r_sy;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_sx <= '0;
                    r_sy <= '0;
                end else if (w_accept) begin
                    r_sx <= '0;
                    r_sy <= '0;
                end else if (w_emit) begin
                    r_sx <= w_sx_last ? '0 : r_sx + SW'(1);
                    if (w_row_end) r_sy <= w_sy_last ? '0 : r_sy + SW'(1);
                end
            end
            assign w_sx      = r_sx;
            assign w_sy      = r_sy;
            assign w_sx_last = (r_sx == SW'(SCALE - 1));
            assign w_sy_last = (r_sy == SW'(SCALE - 1));
        end else begin : g_noscale
            assign w_sx      = '0;
            assign w_sy      = '0;
            assign w_sx_last = 1'b1;
            assign w_sy_last = 1'b1;
        end
    endgenerate

    assign w_gx_last   = (r_gx == GXW'(GLYPH_W - 1));
    assign w_gy_last   = (r_gy == GYW'(GLYPH_H - 1));
    assign w_row_end   = w_sx_last & w_gx_last;
    assign w_glyph_end = w_row_end & w_sy_last & w_gy_last;

    // One extra bit so clipping sees coordinates that ran past the screen.
    assign w_xsum = XS'(r_x0) + XS'(r_gx) * XS'(SCALE) + XS'(w_sx);
    assign w_ysum = YS'(r_y0) + YS'(r_gy) * YS'(SCALE) + YS'(w_sy);
    assign w_idx  = IW'(r_gy) * IW'(GLYPH_W) + IW'(r_gx);
    assign w_bit  = r_pat[IW'(NPIX - 1) - w_idx];
    assign w_vis  = (CLIP == 0) ||
                    ((w_xsum <= XS'(X_MAX)) && (w_ysum <= YS'(Y_MAX)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pat    <= '0;
            r_x0     <= '0;
            r_y0     <= '0;
            r_fg     <= '0;
            r_bg     <= '0;
            r_gx     <= '0;
            r_gy     <= '0;
            r_fin    <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
        end else begin
            r_plot <= 1'b0;
            if (w_accept) begin
                r_pat <= pattern;
                r_x0  <= x0;
                r_y0  <= y0;
                r_fg  <= fg_color;
                r_bg  <= bg_color;
                r_gx  <= '0;
                r_gy  <= '0;
                r_fin <= 1'b0;
            end else if (w_emit) begin
                r_x      <= w_xsum[X_W-1:0];
                r_y      <= w_ysum[Y_W-1:0];
                r_colour <= w_bit ? r_fg : r_bg;
                r_plot   <= (w_bit | (DRAW_BG != 0)) & w_vis;
                if (w_sx_last) r_gx <= w_gx_last ? '0 : r_gx + GXW'(1);
                if (w_row_end & w_sy_last) r_gy <= w_gy_last ? '0 : r_gy + GYW'(1);
                if (w_glyph_end) r_fin <= 1'b1;
            end
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = (r_state == S_DRAW);
    assign done   = (r_state == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_glyph_plotter.sv
`default_nettype none
// ============================================================================
// tb_glyph_plotter : scoreboard bench over three parameterisations
// Rev 1.0
// ============================================================================
module tb_glyph_plotter;
    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
    } pix_t;
    typedef struct packed {
        int         lat;
        int         plots;
        int         fgs;
        logic [2:0] fg;
    } dexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [2:0]        start;
    logic [2:0][14:0]  pattern;
    logic [2:0][7:0]   x0;
    logic [2:0][6:0]   y0;
    logic [2:0][2:0]   fg, bg;
    logic [2:0][7:0]   xo;
    logic [2:0][6:0]   yo;
    logic [2:0][2:0]   co;
    logic [2:0]        plot_o, busy_o, done_o;

    // instance 0: defaults, 1: SCALE=2 opaque, 2: wrap (no clipping)
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            glyph_plotter #(
                .SCALE   (gi == 1 ? 2 : 1),
                .DRAW_BG (gi == 1 ? 1 : 0),
                .CLIP    (gi == 2 ? 0 : 1)
            ) u_dut (
                .clk      (clk),
                .reset    (rst_n),
                .start    (start[gi]),
                .pattern  (pattern[gi]),
                .x0       (x0[gi]),
                .y0       (y0[gi]),
                .fg_color (fg[gi]),
                .bg_color (bg[gi]),
                .x        (xo[gi]),
                .y        (yo[gi]),
                .colour   (co[gi]),
                .plot     (plot_o[gi]),
                .busy     (busy_o[gi]),
                .done     (done_o[gi])
            );
        end
    endgenerate

    pix_t  exp_q  [3][$];
    dexp_t done_q [3][$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    tick = 0;
    bit    end_req = 0;
    int    cyc [3];
    int    pcnt [3];
    int    fcnt [3];
    bit    bprev [3];

    task automatic expect_glyph(input int g, input logic [14:0] p, input int ax, input int ay,
                                input logic [2:0] f, input logic [2:0] b,
                                input int plots, input int fgs);
        int s, xs, ys;
        bit pb, vis;
        pix_t e;
        dexp_t d;
        s = (g == 1) ? 2 : 1;
        for (int gy = 0; gy < 5; gy++)
            for (int sy = 0; sy < s; sy++)
                for (int gx = 0; gx < 3; gx++)
                    for (int sx = 0; sx < s; sx++) begin
                        xs  = ax + gx * s + sx;
                        ys  = ay + gy * s + sy;
                        pb  = p[14 - (gy * 3 + gx)];
                        vis = (g == 2) || (xs <= 159 && ys <= 119);
                        e.x = xs[7:0];
                        e.y = ys[6:0];
                        e.c = pb ? f : b;
                        e.p = (pb || g == 1) && vis;
                        exp_q[g].push_back(e);
                    end
        d.lat   = 15 * s * s + 1;
        d.plots = plots;
        d.fgs   = fgs;
        d.fg    = f;
        done_q[g].push_back(d);
    endtask

    task automatic launch(input int g, input logic [14:0] p, input int ax, input int ay,
                          input logic [2:0] f, input logic [2:0] b,
                          input int plots, input int fgs, input bit hold);
        @(negedge clk);
        start[g]   = 1'b1;
        pattern[g] = p;
        x0[g]      = ax[7:0];
        y0[g]      = ay[6:0];
        fg[g]      = f;
        bg[g]      = b;
        expect_glyph(g, p, ax, ay, f, b, plots, fgs);
        @(posedge clk);
        #1;
        if (!hold) start[g] = 1'b0;
        pattern[g] = ~p;
        x0[g]      = x0[g] + 8'd3;
        y0[g]      = y0[g] + 7'd1;
        fg[g]      = ~f;
        bg[g]      = ~b;
    endtask

    task automatic wait_done(input int g);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_o[g]) break;
        end
    endtask

    always @(negedge clk) begin
        pix_t  e;
        dexp_t d;
        tick++;
        for (int g = 0; g < 3; g++) begin
            if (!rst_n) begin
                n_chk++;
                if (xo[g] != 0 || yo[g] != 0 || co[g] != 0 || plot_o[g] || busy_o[g] || done_o[g]) begin
                    n_fail++;
                    $display("FAIL reset_outputs[%0d]: got x=%0d y=%0d colour=%0d plot=%0b busy=%0b done=%0b, required all 0",
                             g, xo[g], yo[g], co[g], plot_o[g], busy_o[g], done_o[g]);
                end
                bprev[g] = 1'b0;
            end else begin
                if (busy_o[g] && !bprev[g]) begin
                    cyc[g]  = 0;
                    pcnt[g] = 0;
                    fcnt[g] = 0;
                end else begin
                    cyc[g]++;
                end
                if (busy_o[g] && bprev[g]) begin
                    n_chk++;
                    if (exp_q[g].size() == 0) begin
                        n_fail++;
                        $display("FAIL pixel[%0d]: got unexpected pixel x=%0d y=%0d plot=%0b, required none",
                                 g, xo[g], yo[g], plot_o[g]);
                    end else begin
                        e = exp_q[g].pop_front();
                        if (xo[g] != e.x || yo[g] != e.y || co[g] != e.c || plot_o[g] != e.p) begin
                            n_fail++;
                            $display("FAIL pixel[%0d] t=%0t: got x=%0d y=%0d colour=%0d plot=%0b, required x=%0d y=%0d colour=%0d plot=%0b",
                                     g, $time, xo[g], yo[g], co[g], plot_o[g], e.x, e.y, e.c, e.p);
                        end
                    end
                    if (plot_o[g]) begin
                        pcnt[g]++;
                        if (done_q[g].size() > 0 && co[g] == done_q[g][0].fg) fcnt[g]++;
                    end
                end
                if (done_o[g]) begin
                    n_chk++;
                    if (done_q[g].size() == 0) begin
                        n_fail++;
                        $display("FAIL done[%0d]: got unexpected done pulse, required none", g);
                    end else begin
                        d = done_q[g].pop_front();
                        if (cyc[g] != d.lat) begin
                            n_fail++;
                            $display("FAIL done_latency[%0d]: got %0d, required %0d", g, cyc[g], d.lat);
                        end
                        n_chk++;
                        if (pcnt[g] != d.plots) begin
                            n_fail++;
                            $display("FAIL plot_count[%0d]: got %0d, required %0d", g, pcnt[g], d.plots);
                        end
                        n_chk++;
                        if (fcnt[g] != d.fgs) begin
                            n_fail++;
                            $display("FAIL fg_plot_count[%0d]: got %0d, required %0d", g, fcnt[g], d.fgs);
                        end
                    end
                end
                bprev[g] = busy_o[g];
            end
        end
        if (tick > 20000) begin
            n_fail++;
            $display("FAIL watchdog: got %0d cycles, required completion within 20000", tick);
        end
        if (end_req || tick > 20000) begin
            for (int g = 0; g < 3; g++) begin
                n_chk++;
                if (exp_q[g].size() != 0 || done_q[g].size() != 0) begin
                    n_fail++;
                    $display("FAIL leftover[%0d]: got %0d pixels and %0d done pulses outstanding, required 0",
                             g, exp_q[g].size(), done_q[g].size());
                end
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    initial begin
        rst_n   = 1'b0;
        start   = '0;
        pattern = '0;
        x0      = '0;
        y0      = '0;
        fg      = '0;
        bg      = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // transparent "0" at (10,20): 12 lit pixels
        launch(0, 15'b111_101_101_101_111, 10, 20, 3'd5, 3'd2, 12, 12, 1'b0);
        wait_done(0);
        // SCALE=2 opaque: 60 plots, 48 foreground
        launch(1, 15'b111_101_101_101_111, 0, 0, 3'd6, 3'd1, 60, 48, 1'b0);
        wait_done(1);
        // clipped at the bottom-right corner: 2 columns x 3 rows visible
        launch(0, 15'h7FFF, 158, 117, 3'd7, 3'd0, 6, 6, 1'b0);
        wait_done(0);
        // wrapping columns 254,255,0
        launch(2, 15'h7FFF, 254, 5, 3'd4, 3'd3, 15, 15, 1'b0);
        wait_done(2);

        // start held through the draw; second glyph accepted in the DONE cycle
        launch(0, 15'b010_111_010_111_010, 30, 40, 3'd1, 3'd0, 9, 9, 1'b1);
        x0[0]      = 8'd50;
        y0[0]      = 7'd60;
        pattern[0] = 15'b111_001_111_100_111;
        fg[0]      = 3'd2;
        bg[0]      = 3'd4;
        expect_glyph(0, 15'b111_001_111_100_111, 50, 60, 3'd2, 3'd4, 11, 11);
        wait_done(0);
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        x0[0]    = 8'd99;
        wait_done(0);

        // asynchronous reset in the middle of a draw, then a clean redraw
        launch(0, 15'b111_101_101_101_111, 20, 30, 3'd3, 3'd1, 12, 12, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q[0].delete();
        done_q[0].delete();
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        launch(0, 15'b111_101_101_101_111, 20, 30, 3'd3, 3'd1, 12, 12, 1'b0);
        wait_done(0);

        repeat (3) @(negedge clk);
        end_req = 1'b1;
    end
endmodule
`default_nettype wire
